// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared types and defaults for the regfile write-port arbiter
package regfile_arb_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_MD
  } grant_e;

  // Default FIFO entry layout: destination register plus result data
  typedef struct packed {
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
  } md_entry_t;

endpackage

// File: rtl/md_result_fifo.sv
// rtl/md_result_fifo.sv - circular buffer holding mul/div results awaiting the write port
module md_result_fifo
  import regfile_arb_pkg::*;
#(
  parameter type item_t = md_entry_t,
  parameter int  DEPTH  = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  item_t push_data,
  input  logic  pop,
  output item_t head,
  output logic  full,
  output logic  empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  item_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage is not reset; validity is tracked entirely by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the RegFile write port between WB and the mul/div unit
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DW           = 32,
  parameter int AW           = 5,
  parameter int MQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          PCclk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  input  logic          md_valid,
  input  logic [AW-1:0] md_reg,
  input  logic [DW-1:0] md_data,
  output logic          md_ready,
  input  logic          md_issue,
  input  logic [AW-1:0] md_issue_reg,
  input  logic [AW-1:0] chk_regA,
  input  logic [AW-1:0] chk_regB,
  output logic          hazard,
  output logic [31:0]   busy_mask,
  output logic          wb_hold,
  output logic          RegWrite,
  output logic [AW-1:0] regW,
  output logic [DW-1:0] Wdat
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        push_entry;
  entry_t        head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  grant_e        grant;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   busy;
  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;

  assign md_ready   = !fifo_full && !rst;
  assign push       = md_valid && md_ready;
  assign push_entry = '{dst: md_reg, data: md_data};
  assign wb_hold    = (starve_cnt == SW'(STARVE_LIMIT));

  md_result_fifo #(
    .item_t (entry_t),
    .DEPTH  (MQ_DEPTH)
  ) u_fifo (
    .clk       (PCclk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Grant: forced drain under hold, else pipeline first, else idle-slot drain; wb is ignored while held
  always_comb begin
    grant = GNT_NONE;
    if (wb_hold && !fifo_empty) begin
      grant = GNT_MD;
    end else if (wb_valid && !wb_hold) begin
      grant = GNT_WB;
    end else if (!fifo_empty) begin
      grant = GNT_MD;
    end
  end

  assign pop = (grant == GNT_MD);

  // Registered write port; register-0 targets are dropped but still consume their grant
  always_ff @(posedge PCclk) begin
    if (rst) begin
      RegWrite <= 1'b0;
      regW     <= '0;
      Wdat     <= '0;
    end else begin
      case (grant)
        GNT_WB: begin
          RegWrite <= (wb_reg != REG_ZERO);
          regW     <= wb_reg;
          Wdat     <= wb_data;
        end
        GNT_MD: begin
          RegWrite <= (head.dst != REG_ZERO);
          regW     <= head.dst;
          Wdat     <= head.data;
        end
        default: begin
          RegWrite <= 1'b0;
        end
      endcase
    end
  end

  // Starvation counter: counts cycles a buffered head waits, saturating at the hold threshold
  always_ff @(posedge PCclk) begin
    if (rst || fifo_empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Scoreboard set/clear masks; applying set after clear makes a same-register issue win
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (md_issue && (md_issue_reg != REG_ZERO)) begin
      set_mask[md_issue_reg] = 1'b1;
    end
    if (pop) begin
      clr_mask[head.dst] = 1'b1;
    end
  end

  // Scoreboard state; bit 0 is held clear since r0 never carries a real result
  always_ff @(posedge PCclk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
    end
  end

  assign busy_mask = busy;
  assign hazard    = busy[chk_regA] | busy[chk_regB];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        PCclk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic        md_issue;
  logic [4:0]  md_issue_reg;
  logic [4:0]  chk_regA;
  logic [4:0]  chk_regB;
  logic        hazard;
  logic [31:0] busy_mask;
  logic        wb_hold;
  logic        RegWrite;
  logic [4:0]  regW;
  logic [31:0] Wdat;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter dut (
    .PCclk        (PCclk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .md_valid     (md_valid),
    .md_reg       (md_reg),
    .md_data      (md_data),
    .md_ready     (md_ready),
    .md_issue     (md_issue),
    .md_issue_reg (md_issue_reg),
    .chk_regA     (chk_regA),
    .chk_regB     (chk_regB),
    .hazard       (hazard),
    .busy_mask    (busy_mask),
    .wb_hold      (wb_hold),
    .RegWrite     (RegWrite),
    .regW         (regW),
    .Wdat         (Wdat)
  );

  initial begin
    PCclk = 1'b0;
    forever #5 PCclk = ~PCclk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed still running, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCclk);
    #2;
  endtask

  always @(negedge PCclk) begin
    if (!rst && wb_hold === 1'b1) chk("wb_hold_protocol", {63'd0, wb_valid}, 64'd0);
  end

  initial begin
    rst = 1'b1;
    wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    md_valid = 1'b0; md_reg = '0; md_data = '0;
    md_issue = 1'b0; md_issue_reg = '0;
    chk_regA = '0; chk_regB = '0;

    // reset state
    step();
    chk("rst_md_ready", md_ready, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_regw", regW, 0);
    chk("rst_wdat", Wdat, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_wb_hold", wb_hold, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_md_ready", md_ready, 1);

    // pipeline-only writes
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'hDEADBEEF;
    step();
    chk("wb_regwrite", RegWrite, 1);
    chk("wb_regw", regW, 3);
    chk("wb_wdat", Wdat, 32'hDEADBEEF);
    wb_reg = 5'd0; wb_data = 32'h55;
    step();
    chk("wb_r0_dropped", RegWrite, 0);
    wb_valid = 1'b0;
    step();
    chk("idle_regwrite", RegWrite, 0);

    // mul/div path with scoreboard
    md_issue = 1'b1; md_issue_reg = 5'd7;
    step();
    md_issue = 1'b0;
    chk("md_busy_set", busy_mask, 32'h0000_0080);
    chk_regA = 5'd7; chk_regB = 5'd0;
    #1 chk("hazard_a", hazard, 1);
    chk_regA = 5'd3; chk_regB = 5'd7;
    #1 chk("hazard_b", hazard, 1);
    chk_regA = 5'd3; chk_regB = 5'd3;
    #1 chk("hazard_none", hazard, 0);
    md_valid = 1'b1; md_reg = 5'd7; md_data = 32'h12;
    step();
    md_valid = 1'b0;
    chk("md_lat1_regwrite", RegWrite, 0);
    chk("md_lat1_busy", busy_mask, 32'h0000_0080);
    step();
    chk("md_regwrite", RegWrite, 1);
    chk("md_regw", regW, 7);
    chk("md_wdat", Wdat, 32'h12);
    chk("md_busy_clr", busy_mask, 0);

    // priority and full FIFO
    wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h100;
    md_valid = 1'b1; md_reg = 5'd10; md_data = 32'hA1;
    step();
    wb_reg = 5'd5; wb_data = 32'h101;
    md_reg = 5'd11; md_data = 32'hA2;
    #1 chk("count1_md_ready", md_ready, 1);
    chk("prio_wb_first", regW, 4);
    step();
    md_valid = 1'b0;
    wb_reg = 5'd6; wb_data = 32'h102;
    #1 chk("full_md_ready", md_ready, 0);
    chk("prio_wb_second", regW, 5);
    step();
    chk("prio_wb_third_w", Wdat, 32'h102);
    chk("prio_wb_third_we", RegWrite, 1);
    wb_valid = 1'b0;
    step();
    chk("drain0_regw", regW, 10);
    chk("drain0_wdat", Wdat, 32'hA1);
    chk("drain0_md_ready", md_ready, 1);
    step();
    chk("drain1_regw", regW, 11);
    chk("drain1_wdat", Wdat, 32'hA2);
    step();
    chk("drain_done", RegWrite, 0);

    // starvation guard
    wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'h77;
    md_valid = 1'b1; md_reg = 5'd12; md_data = 32'h00C0FFEE;
    step();
    md_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("starve_no_hold", wb_hold, 0);
      chk("starve_wb_regw", regW, 1);
      step();
    end
    chk("starve_hold", wb_hold, 1);
    wb_valid = 1'b0;
    step();
    chk("starve_md_regwrite", RegWrite, 1);
    chk("starve_md_regw", regW, 12);
    chk("starve_md_wdat", Wdat, 32'h00C0FFEE);
    chk("starve_hold_clear", wb_hold, 0);

    // set/clear race on r9
    md_issue = 1'b1; md_issue_reg = 5'd9;
    step();
    md_issue = 1'b0;
    md_valid = 1'b1; md_reg = 5'd9; md_data = 32'h99;
    chk("race_busy_pre", busy_mask, 32'h0000_0200);
    step();
    md_valid = 1'b0;
    md_issue = 1'b1; md_issue_reg = 5'd9;
    step();
    md_issue = 1'b0;
    chk("race_pop_write", regW, 9);
    chk("race_set_wins", busy_mask, 32'h0000_0200);
    md_valid = 1'b1; md_reg = 5'd9; md_data = 32'h9A;
    step();
    md_valid = 1'b0;
    step();
    step();
    chk("race_second_clear", busy_mask, 0);
    chk("race_second_wdat", Wdat, 32'h9A);

    // reset mid-drain
    wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'h22;
    md_issue = 1'b1; md_issue_reg = 5'd13;
    md_valid = 1'b1; md_reg = 5'd13; md_data = 32'h1;
    step();
    md_issue_reg = 5'd14;
    md_reg = 5'd14; md_data = 32'h2;
    step();
    md_valid = 1'b0; md_issue = 1'b0; wb_valid = 1'b0;
    chk("pre_rst_busy", busy_mask, 32'h0000_6000);
    #1 chk("pre_rst_full", md_ready, 0);
    rst = 1'b1;
    step();
    chk("mid_rst_md_ready", md_ready, 0);
    chk("mid_rst_regwrite", RegWrite, 0);
    chk("mid_rst_busy", busy_mask, 0);
    rst = 1'b0;
    step();
    chk("after_rst_md_ready", md_ready, 1);
    chk("after_rst_regwrite", RegWrite, 0);
    chk("after_rst_busy", busy_mask, 0);
    step();
    chk("after_rst_no_drain1", RegWrite, 0);
    step();
    chk("after_rst_no_drain2", RegWrite, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port between the in-order pipeline writeback and the multi-cycle mul/div unit. Mul/div results are buffered in a small FIFO and drained in cycles the pipeline does not write. A destination scoreboard flags RAW hazards on registers with outstanding mul/div results. A starvation guard forces a pipeline bubble so that buffered results always retire. The block sits between the WB stage / mul/div unit and the RegFile write inputs (RegWrite, regW, Wdat).

## Interface
- DW, 32, data width
- AW, 5, register index width (32 registers)
- MQ_DEPTH, 2, mul/div result FIFO depth (power of 2, ≥2)
- STARVE_LIMIT, 8, consecutive blocked cycles before wb_hold is forced

Ports:
- PCclk  in  1  single clock; every register in the block updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- wb_valid  in  1  pipeline writeback request; cannot be stalled
- wb_reg  in  AW  pipeline destination register
- wb_data  in  DW  pipeline write data
- md_valid  in  1  mul/div result valid
- md_reg  in  AW  mul/div destination register
- md_data  in  DW  mul/div result
- md_ready  out  1  FIFO can accept a result
- md_issue  in  1  a mul/div op is issued this cycle
- md_issue_reg  in  AW  destination register of the issued op
- chk_regA, chk_regB  in  AW  source registers of the instruction in decode
- hazard  out  1  either source register is pending in the scoreboard
- busy_mask  out  32  scoreboard bits
- wb_hold  out  1  pipeline must present wb_valid=0 this cycle
- RegWrite  out  1  RegFile write enable
- regW  out  AW  RegFile write index
- Wdat  out  DW  RegFile write data

## Operation
- Accept: md_valid & md_ready pushes {md_reg, md_data} into the FIFO.
- md_ready is 1 when count < MQ_DEPTH, and 0 while rst is high.
- Grant priority each cycle:
  - If wb_hold is 1 and the FIFO is non-empty, grant the FIFO (GNT_MD).
  - Else if wb_valid is 1, grant the pipeline (GNT_WB).
  - Else if the FIFO is non-empty, grant the FIFO (GNT_MD).
  - Else no grant (GNT_NONE).
- A GNT_MD grant pops the FIFO head.
- Push and pop in the same cycle leave count unchanged.
- A result pushed into an empty FIFO is poppable no earlier than the next cycle.
- A granted write to register 0 is dropped: RegWrite stays 0. A register-0 FIFO entry is still popped.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- wb_hold = (counter == STARVE_LIMIT). wb_valid=1 while wb_hold=1 is a protocol violation; the bench asserts on it, and the arbiter ignores wb in that cycle.
- Scoreboard:
  - md_issue with md_issue_reg≠0 sets busy[md_issue_reg].
  - A GNT_MD pop clears busy[head.reg].
  - If set and clear hit the same register in one cycle, set wins.
  - Bit 0 is always 0.
- hazard = busy[chk_regA] | busy[chk_regB], combinational from registered busy bits. Index 0 never hazards.
- A pipeline write to a busy register does not change busy.

## Timing
- RegWrite, regW and Wdat are registered: a grant in cycle N drives them during cycle N+1.
- Pipeline writeback latency is 1 cycle. Minimum mul/div latency, accept to RegWrite, is 2 cycles.
- Outputs stay stable for a full PCclk period, so the RegFile write-phase sampling is safe.
- Reset values: RegWrite=0, regW=0, Wdat=0, md_ready=0 while rst is high (1 in the first cycle after), busy_mask=0, hazard=0, wb_hold=0. FIFO is empty and the starvation counter is 0.
- Reset mid-operation: FIFO contents and scoreboard are discarded. No write is issued in the cycle after rst.
- Worst-case FIFO drain with continuous wb_valid: one entry per STARVE_LIMIT+1 cycles.

## Structure
- Package regfile_arb_pkg holds:
  - DW and AW defaults
  - REG_ZERO = 5'd0
  - grant enum {GNT_NONE, GNT_WB, GNT_MD}
  - FIFO entry struct {reg, data}
- Sub-module md_result_fifo holds the circular buffer with wrap-around pointers and its count, with push/pop/full/empty ports. Arbitration, scoreboard and starvation logic live in regfile_wb_arbiter.

## Test plan
- Pipeline-only writes: wb_valid with (3, 0xDEADBEEF) in cycle 5 → RegWrite=1, regW=3, Wdat=0xDEADBEEF in cycle 6. wb_reg=0 → RegWrite stays 0.
- Mul/div path: md_issue r7 in cycle 2 → busy[7]=1, and chk_regA=7 gives hazard=1. md result (7, 0x12) in cycle 6 with idle pipeline → write in cycle 8, busy[7]=0 in cycle 8.
- Priority and full FIFO: two md results while wb_valid is held high → md_ready=0 at count 2, pipeline writes win, and the FIFO drains in order once wb_valid drops.
- Starvation: one buffered result with continuous wb_valid → wb_hold=1 after 8 blocked cycles, the md write issues the next cycle, and the counter returns to 0.
- Set/clear race: md_issue r9 in the same cycle the FIFO pops a prior r9 result → busy[9] stays 1.
- Reset mid-drain: rst with 2 buffered entries → no RegWrite afterwards, busy_mask=0, md_ready=1 in the cycle after rst falls.
